// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets within the 256-byte I/O window of the
// RISC-V core, shared by the I/O controller and anything else that
// decodes it, plus a small helper for packing FIFO occupancy into
// the status word.
package mmio_pkg;

    localparam logic [7:0] MMIO_UART_CTRL = 8'h00;  // R: {rx_nonempty, tx_notfull}
    localparam logic [7:0] MMIO_UART_RX   = 8'h04;  // R: pop RX head
    localparam logic [7:0] MMIO_UART_TX   = 8'h08;  // W: push TX byte
    localparam logic [7:0] MMIO_CYC       = 8'h10;  // R: cycle counter
    localparam logic [7:0] MMIO_INST      = 8'h14;  // R: retired-instruction counter
    localparam logic [7:0] MMIO_CTR_RST   = 8'h18;  // W: zero all counters
    localparam logic [7:0] MMIO_STATUS    = 8'h1C;  // R: counts/flags, W: clear flags
    localparam logic [7:0] MMIO_BR        = 8'h20;  // R: branch counter (optional)
    localparam logic [7:0] MMIO_BR_TAKEN  = 8'h24;  // R: taken-branch counter (optional)

    // Low byte of a FIFO occupancy count, whatever width the FIFO uses.
    function automatic logic [7:0] cnt_byte(input logic [31:0] c);
        return c[7:0];
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy.
//   clk, rst        clock, synchronous active-high reset (empties FIFO)
//   push, push_data write request; ignored while full
//   pop, head       read request (ignored while empty); head is current front
//   full, empty     status from registered occupancy only
//   count           current occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap naturally), >= 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-pop occupancy, so a push into a full FIFO
    // is dropped even when a pop frees a slot on the same edge.
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data only; reset just invalidates it through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block of the 3-stage RISC-V core.
// Decodes loads/stores in the 256-byte window at BASE_ADDR, buffers UART
// RX/TX bytes in two sync_fifo instances and keeps cycle and retired-
// instruction counters. Read data is registered (1-cycle, like DMEM).
//   clk, rst                   clock, synchronous active-high reset
//   req_addr/wdata/we/re       CPU request from the execute stage
//   rdata                      read data, valid the cycle after req_re
//   inst_retire                one instruction retired this cycle
//   br_retire, br_taken        branch retire info (MMIO_BRANCH_CTR_EN only)
//   rx_data/rx_valid/rx_ready  byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
// Build option: define MMIO_BRANCH_CTR_EN to add branch and taken-branch
// counters at offsets 0x20/0x24.
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    input  logic        req_re,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    input  logic        br_retire,
    input  logic        br_taken,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]       off;
    logic             hit, wr_en, rd_en;
    logic             tx_push, rx_pop, ctr_clr, flag_clr;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]       rx_head;
    logic [RX_CW-1:0] rx_count;
    logic [TX_CW-1:0] tx_count;
    logic             rx_ovf, tx_ovf;
    logic [31:0]      cyc_cnt, inst_cnt;
    logic [31:0]      rd_val;

    assign off      = req_addr[7:0];
    assign hit      = (req_addr[31:8] == BASE_ADDR[31:8]);
    assign wr_en    = hit && (|req_we);
    assign rd_en    = hit && req_re;
    assign tx_push  = wr_en && (off == MMIO_UART_TX);
    assign rx_pop   = rd_en && (off == MMIO_UART_RX);
    assign ctr_clr  = wr_en && (off == MMIO_CTR_RST);
    assign flag_clr = wr_en && (off == MMIO_STATUS);

    // Handshake outputs come straight from registered FIFO occupancy.
    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (req_wdata[7:0]),
        .pop       (tx_ready),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    // A new overflow in the same cycle as a clear write is kept, so an
    // overflow event is never silently lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (flag_clr) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_push && tx_full) tx_ovf <= 1'b1;
            if (rx_valid && rx_full) rx_ovf <= 1'b1;
        end
    end

    // Clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || ctr_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end

`ifdef MMIO_BRANCH_CTR_EN
    logic [31:0] br_cnt, br_taken_cnt;

    always_ff @(posedge clk) begin
        if (rst || ctr_clr) begin
            br_cnt       <= '0;
            br_taken_cnt <= '0;
        end else if (br_retire) begin
            br_cnt <= br_cnt + 32'd1;
            if (br_taken) br_taken_cnt <= br_taken_cnt + 32'd1;
        end
    end
`else
    logic unused_br;
    assign unused_br = &{1'b0, br_retire, br_taken};
`endif

    logic unused_wdata;
    assign unused_wdata = &{1'b0, req_wdata[31:8]};

    always_comb begin
        rd_val = '0;
        if (rd_en) begin
            case (off)
                MMIO_UART_CTRL: rd_val = {30'b0, !rx_empty, !tx_full};
                MMIO_UART_RX:   rd_val = rx_empty ? 32'd0 : {24'b0, rx_head};
                MMIO_CYC:       rd_val = cyc_cnt;
                MMIO_INST:      rd_val = inst_cnt;
                MMIO_STATUS:    rd_val = {8'b0, cnt_byte(32'(tx_count)),
                                          cnt_byte(32'(rx_count)), 6'b0, rx_ovf, tx_ovf};
`ifdef MMIO_BRANCH_CTR_EN
                MMIO_BR:        rd_val = br_cnt;
                MMIO_BR_TAKEN:  rd_val = br_taken_cnt;
`endif
                default:        rd_val = '0;
            endcase
        end
    end

    // Captured on the same edge as the RX pop, so a 0x04 read returns the
    // pre-pop head.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= rd_val;
    end

endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Memory-mapped I/O controller for the 3-stage RISC-V core, the parametrised successor of the core's hard-wired UART/CSR glue. It decodes CPU load/store requests in the I/O region, buffers UART traffic in independent RX and TX FIFOs of configurable depth, and maintains 32-bit cycle and retired-instruction counters. Read data returns one cycle after the request, matching DMEM timing so the memory/writeback stage muxes it like any other memory.

## Interface
- `BASE_ADDR`, 32'h8000_0000: I/O region base; a request hits when `addr[31:8] == BASE_ADDR[31:8]`.
- `RX_DEPTH`, 8: RX FIFO entries; power of 2, ≥2.
- `TX_DEPTH`, 8: TX FIFO entries; power of 2, ≥2.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_addr` in 32: byte address from execute stage.
- `req_wdata` in 32: store data.
- `req_we` in 4: byte write enables; any bit set = write.
- `req_re` in 1: load request.
- `rdata` out 32: registered read data, valid the cycle after `req_re`.
- `inst_retire` in 1: one instruction retired this cycle.
- `br_retire`, `br_taken` in 1: branch retired / was taken (used only with the macro below).
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: from UART receiver.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: to UART transmitter.

## Operation
- Offset map (`addr[7:0]`):
  - 0x00 R: `{30'b0, rx_nonempty, tx_notfull}`.
  - 0x04 R: `{24'b0, rx_head}`, pops RX; if empty, returns 0 and does not pop.
  - 0x08 W: pushes `wdata[7:0]` into TX; if full, byte dropped and `tx_ovf` set.
  - 0x10 R: cycle counter. 0x14 R: instruction counter.
  - 0x18 W: any write zeroes all counters.
  - 0x1C R: `{8'b0, tx_count[7:0], rx_count[7:0], 6'b0, rx_ovf, tx_ovf}`; W: clears both overflow flags.
- Unmapped offsets, and requests outside the region, read 0 and writes are ignored. `req_re` and `req_we` both set: write applies, read data still returned.
- RX fill: `rx_ready = !rx_full`; push on `rx_valid && rx_ready`. `rx_ovf` is set when `rx_valid` is high while RX is full; the byte stays in the UART.
- TX drain: `tx_valid = !tx_empty`, `tx_data = tx_head`; pop on `tx_valid && tx_ready`.
- Simultaneous push and pop on the same FIFO: count unchanged, both complete. On TX, full status is evaluated before the pop, so a CPU push to a full FIFO is dropped even if a pop happens the same cycle.
- Counters:
  - Cycle counter increments every non-reset cycle.
  - Instruction counter increments when `inst_retire` is high.
  - Both are 32-bit and wrap 0xFFFF_FFFF→0.
  - A clear write wins over an increment in the same cycle: the counter reads 0 on the next read.

## Timing
- Reset values:
  - outputs: `rdata` 0, `tx_valid` 0, `rx_ready` 1;
  - internal state: FIFOs empty, pointers 0, counters 0, flags 0.
- Reset mid-transfer discards all FIFO contents. The UART shares `rst`.
- Read latency is 1 cycle. The RX pop and the `rdata` capture happen on the same edge, so `rdata` holds the pre-pop head.
- Writes take effect at the edge ending the request cycle. A status read in the following cycle reflects the write.
- A byte pushed to TX at edge N drives `tx_valid` high from cycle N+1.
- `rx_ready` and `tx_valid` are functions of registered state only, with no combinational path from `req_*`.

## Configuration
- `MMIO_BRANCH_CTR_EN` defined:
  - adds 32-bit branch counter (increments on `br_retire`) at 0x20;
  - adds taken-branch counter (increments on `br_retire && br_taken`) at 0x24;
  - both are cleared by the 0x18 write.
- Undefined: 0x20/0x24 read 0, `br_*` inputs unused, no counter flops.

## Structure
- Shared package `mmio_pkg`: offset constants (`MMIO_UART_CTRL`, `MMIO_UART_RX`, `MMIO_UART_TX`, `MMIO_CYC`, `MMIO_INST`, `MMIO_CTR_RST`, `MMIO_STATUS`, `MMIO_BR`, `MMIO_BR_TAKEN`).
- One sub-module `sync_fifo` (params `WIDTH`, `DEPTH`; `push`/`pop`/`full`/`empty`/`count`), instantiated twice.

## Test plan
- RX path: drive bytes 0x41, 0x42 on `rx_*`.
  - 0x00 reads 0x3.
  - Two 0x04 reads return 0x41 then 0x42.
  - 0x00 then reads 0x1.
- TX path: write 0x55 to 0x08 with `tx_ready` low.
  - `tx_valid` is high with `tx_data` = 0x55.
  - Raise `tx_ready` for one cycle: `tx_valid` drops.
- TX overflow: with `tx_ready` low, push `TX_DEPTH`+1 bytes.
  - 0x1C shows `tx_count` = 8 and bit0 = 1.
  - Write 0x1C: bit0 clears.
- RX full: push 8 bytes, hold `rx_valid` high.
  - `rx_ready` = 0 and `rx_ovf` = 1.
  - A 0x04 read frees a slot, so `rx_ready` = 1 the next cycle.
- Counters: 10 cycles with `inst_retire` high on 4 of them.
  - 0x14 reads 4.
  - Write 0x18 in the same cycle as `inst_retire`: 0x14 reads 0.
  - With `MMIO_BRANCH_CTR_EN`: 3 `br_retire`, 2 of them taken, give 3 at 0x20 and 2 at 0x24.
- Reset mid-operation: assert `rst` with both FIFOs partially full.
  - Next cycle: `tx_valid` = 0, 0x00 reads 0x1, counters 0.
